// File: rtl/yd_pkg.sv
// Shared Yduck definitions: register-file address constants, LSU FSM encoding
// and default bus widths.
package yd_pkg;

    localparam int AW_DEF      = 16;
    localparam int DW_DEF      = 16;
    localparam int TIMEOUT_DEF = 16;

    localparam logic [3:0] ZEA = 4'd0;
    localparam logic [3:0] DKA = 4'd1;
    localparam logic [3:0] R0A = 4'd2;
    localparam logic [3:0] PCA = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_WB   = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/yd_lsu_timer.sv
// Saturating wait-state counter for the LSU; hit flags the last allowed
// BUS cycle before an abort. TIMEOUT=0 never hits.
module yd_lsu_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CW{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign hit = (TIMEOUT != 0) && (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/yd_lsu.sv
// Yduck load/store unit: one outstanding req/ack transfer to data memory,
// stalls the core via dsv and returns load data on register-file port 1.
module yd_lsu
    import yd_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_req,
    input  logic          st_req,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] st_data,
    input  logic [3:0]    ld_rd,
    output logic          dsv,
    output logic          we1,
    output logic [3:0]    waddr1,
    output logic [DW-1:0] din1,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdata,
    output logic          bus_err
);

    lsu_state_t    state_reg, state_next;
    logic          is_store_reg;
    logic [3:0]    rd_reg;
    logic          bus_req_reg, bus_we_reg, bus_err_reg, we1_reg;
    logic [AW-1:0] bus_addr_reg;
    logic [DW-1:0] bus_wdata_reg, din1_reg;
    logic [3:0]    waddr1_reg;

    logic in_bus, accept, timer_hit, timeout_hit;

    assign in_bus      = (state_reg == ST_BUS);
    assign accept      = (state_reg == ST_IDLE) && (ld_req || st_req);
    assign timeout_hit = in_bus && !bus_ack && timer_hit;

    yd_lsu_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!in_bus),
        .inc   (in_bus && !bus_ack),
        .hit   (timer_hit)
    );

    // A load keeps the core stalled through its ack cycle so the PC advances
    // in the WB cycle instead; a store releases it on the ack itself.
    always_comb begin
        state_next = state_reg;
        dsv        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_BUS;
                    dsv        = 1'b1;
                end
            end
            ST_BUS: begin
                dsv = !(bus_ack && is_store_reg) && !timeout_hit;
                if (bus_ack) begin
                    state_next = is_store_reg ? ST_IDLE : ST_WB;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            is_store_reg  <= 1'b0;
            rd_reg        <= '0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            bus_err_reg   <= 1'b0;
            we1_reg       <= 1'b0;
            waddr1_reg    <= '0;
            din1_reg      <= '0;
        end else begin
            state_reg <= state_next;
            // Store wins when both requests arrive together.
            if (accept) begin
                is_store_reg  <= st_req;
                rd_reg        <= ld_rd;
                bus_addr_reg  <= addr;
                bus_wdata_reg <= st_data;
            end
            bus_req_reg <= (state_next == ST_BUS);
            bus_we_reg  <= (state_next == ST_BUS) && (accept ? st_req : is_store_reg);
            bus_err_reg <= timeout_hit;
            we1_reg     <= (state_next == ST_WB) && (rd_reg != PCA);
            if (in_bus && bus_ack && !is_store_reg) begin
                din1_reg   <= bus_rdata;
                waddr1_reg <= rd_reg;
            end
        end
    end

    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign bus_err   = bus_err_reg;
    assign we1       = we1_reg;
    assign waddr1    = waddr1_reg;
    assign din1      = din1_reg;

endmodule
